spmv_phase_ctrl: RTL
====================

// Module: spmv_phase_ctrl
// PURPOSE
// - Parametrised global phase controller and per-channel DRAM read-address generator for the SpMV accelerator top level.
// - Sequences IDLE -> SCATTER -> GATHER across NUM_ITER iterations, not just one pass.
// - Gates phase exit on per-PE done flags. Stale done levels from the previous phase are ignored.
// - Drives NUM_CH read-address counters (load on partition start, advance by STRIDE per accepted read).
// PARAMETERS
// - NUM_CH      16  number of PE/memory channels (1..64)
// - ADDR_W      32  read-address width per channel
// - STRIDE      1   address increment per accepted read (1..255)
// - ITER_W      8   width of iteration count / counter
// - SETTLE_CYC  2   cycles after phase entry during which pe_done is ignored (>=1)
// PORTS
// - clk             in   1              system clock, all logic on rising edge
// - rst             in   1              synchronous active-high reset
// - start           in   1              begin run; sampled only in IDLE
// - num_iter        in   ITER_W         SCATTER+GATHER iterations; 0 treated as 1; sampled on accepted start
// - pe_done         in   NUM_CH         per-PE phase-complete level (scheduler PE_DONE)
// - new_par_start   in   NUM_CH         per-channel partition start pulse
// - new_raddr       in   NUM_CH*ADDR_W  per-channel partition base address; ch i at [i*ADDR_W +: ADDR_W]
// - r_en            in   NUM_CH         per-channel memory read-ready
// - fifo_full       in   NUM_CH         per-channel PE input FIFO full
// - state           out  2              0=IDLE 1=SCATTER 2=GATHER 3=FINISH; broadcast to PEs/schedulers
// - raddr           out  NUM_CH*ADDR_W  per-channel registered read address
// - rd_issue        out  NUM_CH         combinational: read accepted this cycle on ch i
// - iter_cnt        out  ITER_W         completed-iteration count of the current run
// - busy            out  1              state != IDLE
// - run_done        out  1              one-cycle pulse in FINISH
// - scatter_cycles  out  32             perf counter (see CONFIGURATION)
// - gather_cycles   out  32             perf counter (see CONFIGURATION)
// BEHAVIOUR
// - Reset: state=IDLE; raddr=0 on all channels; iter_cnt=0; phase_cnt=0; done_sticky=0; run_done=0; perf counters=0. Reset mid-run aborts immediately, with no FINISH pulse.
// - IDLE:
//   - start=1 latches num_iter (0 -> 1), clears iter_cnt and done_sticky, and goes to SCATTER next cycle.
//   - start outside IDLE is ignored.
// - phase_cnt: cleared on every phase entry; increments each cycle in SCATTER/GATHER; saturates at SETTLE_CYC.
// - done_sticky[i]: set when pe_done[i]=1 && phase_cnt>=SETTLE_CYC; cleared on every phase entry.
// - Phase exit: when &done_sticky==1, the state changes on the next edge.
//   - All channels done in the same cycle: exit on the next edge.
//   - Channels done in different cycles: exit one edge after the last channel's done.
// - SCATTER exit -> GATHER.
// - GATHER exit:
//   - iter_cnt+1 < num_iter_q: iter_cnt++ and return to SCATTER.
//   - otherwise: iter_cnt++ and go to FINISH.
// - FINISH: run_done=1 for exactly one cycle, then IDLE. iter_cnt holds its value until the next accepted start.
// - Address channel i, priority order:
//   1. rst -> 0
//   2. new_par_start[i] -> new_raddr[i] (a load wins over a simultaneous accepted read; that read is not counted)
//   3. rd_issue[i] -> raddr[i] + STRIDE, modulo 2^ADDR_W (wraps silently)
//   4. otherwise hold
// - rd_issue[i] = r_en[i] & ~fifo_full[i] & (state==SCATTER | state==GATHER) & ~new_par_start[i].
// - Addresses never advance in IDLE or FINISH; raddr holds across phase and iteration boundaries.
// - Latency: start -> state=SCATTER is 1 cycle; last done -> next state is 1 cycle; new_par_start -> raddr visible is 1 cycle.
// CONFIGURATION
// - SPMV_PERF_CNT_EN defined:
//   - scatter_cycles / gather_cycles count cycles spent in SCATTER / GATHER.
//   - Both clear on accepted start, saturate at 32'hFFFF_FFFF, and hold after FINISH.
// - SPMV_PERF_CNT_EN undefined: both outputs are tied to 0 and no counter flops are inferred.
// TESTING
// - rst, start, num_iter=2, all pe_done held 1 -> SCATTER/GATHER each last SETTLE_CYC+1 cycles; sequence S,G,S,G,FINISH; run_done one pulse; iter_cnt=2.
// - ch3 new_par_start with new_raddr=0x100, r_en=1, fifo_full=0 for 4 cycles, STRIDE=1 -> raddr3=0x104; rd_issue3 low on the load cycle.
// - raddr0=0xFFFF_FFFF, ADDR_W=32, one accepted read -> raddr0=0; fifo_full0=1 with r_en0=1 -> raddr0 holds, rd_issue0=0.
// - pe_done bits assert one per cycle on ch0..15 -> exit one edge after ch15's done; pe_done already 1 at phase entry ignored for SETTLE_CYC cycles.
// - rst asserted mid-GATHER with raddr!=0 -> next cycle state=IDLE, all raddr=0, run_done never pulses; start while busy -> no effect.
// - SPMV_PERF_CNT_EN defined, num_iter=1, SCATTER lasts 10 cycles, GATHER 7 -> scatter_cycles=10, gather_cycles=7; undefined -> both read 0.

Source files
------------

// File: rtl/spmv_phase_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spmv_phase_ctrl                                                            |
// | Global IDLE/SCATTER/GATHER/FINISH phase sequencer with per-channel DRAM    |
// | read-address counters. Optional perf counters: define SPMV_PERF_CNT_EN.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module spmv_phase_ctrl #(
  parameter int NUM_CH     = 16,
  parameter int ADDR_W     = 32,
  parameter int STRIDE     = 1,
  parameter int ITER_W     = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ITER_W-1:0]        num_iter,
  input  logic [NUM_CH-1:0]        pe_done,
  input  logic [NUM_CH-1:0]        new_par_start,
  input  logic [NUM_CH*ADDR_W-1:0] new_raddr,
  input  logic [NUM_CH-1:0]        r_en,
  input  logic [NUM_CH-1:0]        fifo_full,
  output logic [1:0]               state,
  output logic [NUM_CH*ADDR_W-1:0] raddr,
  output logic [NUM_CH-1:0]        rd_issue,
  output logic [ITER_W-1:0]        iter_cnt,
  output logic                     busy,
  output logic                     run_done,
  output logic [31:0]              scatter_cycles,
  output logic [31:0]              gather_cycles
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCATTER = 2'd1,
    ST_GATHER  = 2'd2,
    ST_FINISH  = 2'd3
  } state_t;

  localparam int                c_PH_W   = $clog2(SETTLE_CYC + 1);
  localparam logic [c_PH_W-1:0] c_SETTLE = c_PH_W'(SETTLE_CYC);
  localparam logic [ADDR_W-1:0] c_STRIDE = ADDR_W'(STRIDE);

  state_t              r_state;
  logic [c_PH_W-1:0]   r_phase_cnt;
  logic [NUM_CH-1:0]   r_done_sticky;
  logic [ITER_W-1:0]   r_iter_cnt;
  logic [ITER_W-1:0]   r_num_iter_q;
  logic                r_run_done;

  logic                w_active;
  logic                w_settled;
  logic [NUM_CH-1:0]   w_sticky_nxt;
  logic                w_phase_exit;
  logic [ITER_W:0]     w_iter_inc;
  logic                w_more_iter;
  logic                w_start_acc;

  assign w_active     = (r_state == ST_SCATTER) || (r_state == ST_GATHER);
  assign w_settled    = (r_phase_cnt >= c_SETTLE);
  // Exit looks at the done set including this cycle's flags, so the last done costs one edge.
  assign w_sticky_nxt = r_done_sticky | (pe_done & {NUM_CH{w_settled}});
  assign w_phase_exit = w_active && (&w_sticky_nxt);
  assign w_iter_inc   = {1'b0, r_iter_cnt} + (ITER_W + 1)'(1);
  assign w_more_iter  = (w_iter_inc < {1'b0, r_num_iter_q});
  assign w_start_acc  = (r_state == ST_IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_phase_cnt   <= '0;
      r_done_sticky <= '0;
      r_iter_cnt    <= '0;
      r_num_iter_q  <= '0;
      r_run_done    <= 1'b0;
    end else begin
      r_run_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_num_iter_q  <= (num_iter == '0) ? ITER_W'(1) : num_iter;
            r_iter_cnt    <= '0;
            r_done_sticky <= '0;
            r_phase_cnt   <= '0;
            r_state       <= ST_SCATTER;
          end
        end
        ST_SCATTER, ST_GATHER: begin
          if (w_phase_exit) begin
            r_phase_cnt   <= '0;
            r_done_sticky <= '0;
            if (r_state == ST_SCATTER) begin
              r_state <= ST_GATHER;
            end else begin
              r_iter_cnt <= w_iter_inc[ITER_W-1:0];
              if (w_more_iter) begin
                r_state <= ST_SCATTER;
              end else begin
                r_state    <= ST_FINISH;
                r_run_done <= 1'b1;
              end
            end
          end else begin
            r_done_sticky <= w_sticky_nxt;
            if (r_phase_cnt != c_SETTLE) r_phase_cnt <= r_phase_cnt + c_PH_W'(1);
          end
        end
        ST_FINISH: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign state    = r_state;
  assign busy     = (r_state != ST_IDLE);
  assign run_done = r_run_done;
  assign iter_cnt = r_iter_cnt;

  // A partition load masks the read on that channel, so it is never counted.
  assign rd_issue = r_en & ~fifo_full & ~new_par_start & {NUM_CH{w_active}};

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [ADDR_W-1:0] r_addr;
      always_ff @(posedge clk) begin
        if (rst)                   r_addr <= '0;
        else if (new_par_start[i]) r_addr <= new_raddr[i*ADDR_W +: ADDR_W];
        else if (rd_issue[i])      r_addr <= r_addr + c_STRIDE;
      end
      assign raddr[i*ADDR_W +: ADDR_W] = r_addr;
    end
  endgenerate

`ifdef SPMV_PERF_CNT_EN
  logic [31:0] r_scatter_cycles;
  logic [31:0] r_gather_cycles;

  always_ff @(posedge clk) begin
    if (rst || w_start_acc) begin
      r_scatter_cycles <= '0;
      r_gather_cycles  <= '0;
    end else begin
      if (r_state == ST_SCATTER && r_scatter_cycles != 32'hFFFF_FFFF)
        r_scatter_cycles <= r_scatter_cycles + 32'd1;
      if (r_state == ST_GATHER && r_gather_cycles != 32'hFFFF_FFFF)
        r_gather_cycles <= r_gather_cycles + 32'd1;
    end
  end

  assign scatter_cycles = r_scatter_cycles;
  assign gather_cycles  = r_gather_cycles;
`else
  logic w_unused_start_acc;
  assign w_unused_start_acc = w_start_acc;
  assign scatter_cycles     = 32'd0;
  assign gather_cycles      = 32'd0;
`endif

endmodule
`default_nettype wire
